mem_load_unit: RTL and testbench
================================

MEM_LOAD_UNIT -- requirements
Module: mem_load_unit

Interface
REQ-001 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-002 SHALL have port reset, input, 1: asynchronous, active-high; no other reset.
REQ-003 SHALL have es_to_ms_valid in 1 and ms_allowin out 1: EX→MEM handshake.
REQ-004 SHALL have es_load_op in load_op_t (3): NONE, LB, LBU, LH, LHU, LW, LWL, LWR.
REQ-005 SHALL have es_addr_lo in 2 (byte offset) and es_dest in reg_addr_t (5).
REQ-006 SHALL have es_result in uint32_t (non-load result), es_mfc0 in 1 and es_pc in uint32_t.
REQ-007 SHALL have data_ok in 1 and data_rdata in uint32_t: data SRAM response, one per issued load.
REQ-008 SHALL have ws_allowin in 1, flush in 1 (exception/eret discard) and ms_to_ws_valid out 1.
REQ-009 SHALL have forward outputs ms_dest out 5, ms_result out 32, ms_rf_we out 4, ms_mfc0 out 1, ms_data_pending out 1, ms_pc out 32.

Function
REQ-010 SHALL implement states EMPTY, WAIT, READY, DISCARD.
REQ-011 SHALL accept on es_to_ms_valid & ms_allowin; ms_allowin = EMPTY | (READY & ws_allowin).
REQ-012 SHALL go to WAIT on accepting a load, else to READY; one-cycle latency for non-loads.
REQ-013 SHALL, in WAIT on data_ok, register the aligned result and go to READY next cycle; data_ok never completes in the acceptance cycle.
REQ-014 SHALL leave READY when ws_allowin is high: back to EMPTY, or to WAIT/READY if a new op is accepted the same cycle.
REQ-015 SHALL, on flush, move WAIT→DISCARD and EMPTY/READY→EMPTY; flush overrides any same-cycle acceptance.
REQ-016 SHALL leave DISCARD only on data_ok, dropping that response and going to EMPTY, with ms_allowin low throughout.
REQ-017 SHALL drive ms_to_ws_valid = (state == READY) & ~flush.
REQ-018 SHALL force ms_dest = 0 and ms_rf_we = 0 in EMPTY/DISCARD; in WAIT, ms_dest = pending dest, ms_rf_we = 0 and ms_data_pending = 1.
REQ-019 SHALL set ms_rf_we = 1111 for non-loads with dest ≠ 0, otherwise 0000; ms_result = es_result.
REQ-020 SHALL set ms_rf_we = 1111 for LW/LB/LBU/LH/LHU; byte select = addr_lo, half select = addr_lo[1]; sign- or zero-extend per op.
REQ-021 SHALL encode LWL by addr_lo 0/1/2/3: ms_rf_we 1000/1100/1110/1111; rdata[7:0]/[15:0]/[23:0]/[31:0] placed into result MSBs.
REQ-022 SHALL encode LWR by addr_lo 0/1/2/3: ms_rf_we 1111/0111/0011/0001; rdata[31:0]/[31:8]/[31:16]/[31:24] placed into result LSBs.
REQ-023 SHALL drive unwritten ms_result bytes to 0.
REQ-024 SHALL never write register 0: ms_rf_we = 0 whenever dest = 0, loads included.
REQ-025 SHALL treat data_ok in EMPTY/READY as a protocol error and ignore it.

Reset
REQ-026 SHALL on reset enter EMPTY; ms_to_ws_valid, ms_rf_we, ms_dest, ms_mfc0 and ms_data_pending = 0; ms_result and ms_pc = 0.
REQ-027 SHALL, on reset asserted in WAIT, abandon the outstanding load; no DISCARD pass is needed because the memory side is reset together with this block.

Structure
REQ-028 SHALL take load_op_t, reg_addr_t and uint32_t from the shared cpu_defs package and add the load_op_t encoding there.
REQ-029 SHALL place byte/half/LWL/LWR alignment in one combinational sub-module, load_align (inputs: op, addr_lo, rdata, dest; outputs: result, rf_we).

Verification
REQ-030 SHALL check LW addr_lo 0, rdata 0x11223344, data_ok 2 cycles after accept → ms_result 0x11223344, ms_rf_we 1111, valid the cycle after data_ok.
REQ-031 SHALL check LB addr_lo 3 with rdata 0x80FF0000 → result 0xFFFFFF80; LBU → 0x00000080.
REQ-032 SHALL check LWL addr_lo 1 with rdata 0xAABBCCDD → result 0xCCDD0000, rf_we 1100; LWR addr_lo 2 → result 0x0000AABB, rf_we 0011.
REQ-033 SHALL check flush in WAIT followed by data_ok 3 cycles later → no ms_to_ws_valid, ms_allowin low until the data_ok cycle, then EMPTY.
REQ-034 SHALL check back-to-back ALU ops with ws_allowin held high → one per cycle; dest 0 gives rf_we 0000; ws_allowin low holds READY with stable outputs.

Source files
------------

// File: rtl/cpu_defs.sv
// Shared CPU type definitions: register/data widths, load operation encoding
// and the memory-stage state encoding.
package cpu_defs;

  typedef logic [31:0] uint32_t;
  typedef logic [4:0]  reg_addr_t;

  typedef enum logic [2:0] {
    NONE = 3'd0,
    LB   = 3'd1,
    LBU  = 3'd2,
    LH   = 3'd3,
    LHU  = 3'd4,
    LW   = 3'd5,
    LWL  = 3'd6,
    LWR  = 3'd7
  } load_op_t;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_WAIT    = 2'd1,
    S_READY   = 2'd2,
    S_DISCARD = 2'd3
  } ms_state_t;

  localparam logic [3:0] WE_ALL  = 4'b1111;
  localparam logic [3:0] WE_NONE = 4'b0000;

endpackage

// File: rtl/load_align.sv
// Combinational alignment of a data SRAM word into a register write value
// and per-byte write enable for byte, half, word and unaligned word loads.
module load_align
  import cpu_defs::*;
(
  input  load_op_t  op,
  input  logic [1:0] addr_lo,
  input  uint32_t   rdata,
  input  reg_addr_t dest,
  output uint32_t   result,
  output logic [3:0] rf_we
);

  uint32_t     byte_shift;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value undriven and infer a latch.
  always_comb begin
    result     = '0;
    rf_we      = WE_NONE;
    byte_shift = rdata >> {addr_lo, 3'b000};
    sel_byte   = byte_shift[7:0];
    sel_half   = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    unique case (op)
      LB:  begin result = {{24{sel_byte[7]}}, sel_byte};  rf_we = WE_ALL; end
      LBU: begin result = {24'b0, sel_byte};              rf_we = WE_ALL; end
      LH:  begin result = {{16{sel_half[15]}}, sel_half}; rf_we = WE_ALL; end
      LHU: begin result = {16'b0, sel_half};              rf_we = WE_ALL; end
      LW:  begin result = rdata;                          rf_we = WE_ALL; end
      // Unaligned halves: LWL fills from the MSB down, LWR from the LSB up.
      LWL: begin
        result = rdata << {~addr_lo, 3'b000};
        rf_we  = WE_ALL << ~addr_lo;
      end
      LWR: begin
        result = rdata >> {addr_lo, 3'b000};
        rf_we  = WE_ALL >> addr_lo;
      end
      default: ;
    endcase

    if (dest == '0) rf_we = WE_NONE;
  end

endmodule

// File: rtl/mem_load_unit.sv
// Memory pipeline stage: holds one EX op, waits for the data SRAM response on
// loads, aligns it, and forwards the result to writeback.
module mem_load_unit
  import cpu_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       es_to_ms_valid,
  output logic       ms_allowin,
  input  load_op_t   es_load_op,
  input  logic [1:0] es_addr_lo,
  input  reg_addr_t  es_dest,
  input  uint32_t    es_result,
  input  logic       es_mfc0,
  input  uint32_t    es_pc,
  input  logic       data_ok,
  input  uint32_t    data_rdata,
  input  logic       ws_allowin,
  input  logic       flush,
  output logic       ms_to_ws_valid,
  output reg_addr_t  ms_dest,
  output uint32_t    ms_result,
  output logic [3:0] ms_rf_we,
  output logic       ms_mfc0,
  output logic       ms_data_pending,
  output uint32_t    ms_pc
);

  ms_state_t  state_q;
  load_op_t   op_q;
  logic [1:0] addr_lo_q;
  reg_addr_t  dest_q;
  uint32_t    result_q;
  logic [3:0] rf_we_q;
  logic       mfc0_q;
  uint32_t    pc_q;

  uint32_t    align_result;
  logic [3:0] align_rf_we;
  logic       accept;
  logic       es_is_load;

  load_align u_align (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .rdata   (data_rdata),
    .dest    (dest_q),
    .result  (align_result),
    .rf_we   (align_rf_we)
  );

  assign ms_allowin = (state_q == S_EMPTY) || ((state_q == S_READY) && ws_allowin);
  assign accept     = es_to_ms_valid && ms_allowin && !flush;
  assign es_is_load = (es_load_op != NONE);

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_EMPTY;
      op_q      <= NONE;
      addr_lo_q <= '0;
      dest_q    <= '0;
      result_q  <= '0;
      rf_we_q   <= WE_NONE;
      mfc0_q    <= 1'b0;
      pc_q      <= '0;
    end else begin
      unique case (state_q)
        S_EMPTY, S_READY: begin
          if (flush)                                 state_q <= S_EMPTY;
          else if (accept)                           state_q <= es_is_load ? S_WAIT : S_READY;
          else if (state_q == S_READY && ws_allowin) state_q <= S_EMPTY;
        end
        S_WAIT: begin
          // A response arriving with the flush is already consumed; nothing to discard.
          if (flush) state_q <= data_ok ? S_EMPTY : S_DISCARD;
          else if (data_ok) begin
            state_q  <= S_READY;
            result_q <= align_result;
            rf_we_q  <= align_rf_we;
          end
        end
        S_DISCARD: if (data_ok) state_q <= S_EMPTY;
        default: state_q <= S_EMPTY;
      endcase

      if (accept) begin
        op_q      <= es_load_op;
        addr_lo_q <= es_addr_lo;
        dest_q    <= es_dest;
        mfc0_q    <= es_mfc0;
        pc_q      <= es_pc;
        if (!es_is_load) begin
          result_q <= es_result;
          rf_we_q  <= (es_dest == '0) ? WE_NONE : WE_ALL;
        end
      end
    end
  end

  assign ms_to_ws_valid  = (state_q == S_READY) && !flush;
  assign ms_data_pending = (state_q == S_WAIT);
  assign ms_dest         = (state_q == S_WAIT || state_q == S_READY) ? dest_q : '0;
  assign ms_rf_we        = (state_q == S_READY) ? rf_we_q : WE_NONE;
  assign ms_result       = result_q;
  assign ms_mfc0         = mfc0_q;
  assign ms_pc           = pc_q;

endmodule

// File: tb/tb_mem_load_unit.sv
// Directed bench for mem_load_unit: a table of single-op transactions plus
// hand-written sequences for timing, flush, back-pressure and reset.
module tb_mem_load_unit;
  import cpu_defs::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       es_to_ms_valid;
  logic       ms_allowin;
  load_op_t   es_load_op;
  logic [1:0] es_addr_lo;
  reg_addr_t  es_dest;
  uint32_t    es_result;
  logic       es_mfc0;
  uint32_t    es_pc;
  logic       data_ok;
  uint32_t    data_rdata;
  logic       ws_allowin;
  logic       flush;
  logic       ms_to_ws_valid;
  reg_addr_t  ms_dest;
  uint32_t    ms_result;
  logic [3:0] ms_rf_we;
  logic       ms_mfc0;
  logic       ms_data_pending;
  uint32_t    ms_pc;

  int n_pass  = 0;
  int n_total = 0;

  mem_load_unit dut (
    .clk             (clk),
    .reset           (reset),
    .es_to_ms_valid  (es_to_ms_valid),
    .ms_allowin      (ms_allowin),
    .es_load_op      (es_load_op),
    .es_addr_lo      (es_addr_lo),
    .es_dest         (es_dest),
    .es_result       (es_result),
    .es_mfc0         (es_mfc0),
    .es_pc           (es_pc),
    .data_ok         (data_ok),
    .data_rdata      (data_rdata),
    .ws_allowin      (ws_allowin),
    .flush           (flush),
    .ms_to_ws_valid  (ms_to_ws_valid),
    .ms_dest         (ms_dest),
    .ms_result       (ms_result),
    .ms_rf_we        (ms_rf_we),
    .ms_mfc0         (ms_mfc0),
    .ms_data_pending (ms_data_pending),
    .ms_pc           (ms_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    load_op_t   op;
    logic [1:0] addr_lo;
    reg_addr_t  dest;
    uint32_t    data;
    uint32_t    exp_result;
    logic [3:0] exp_we;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input load_op_t op, input logic [1:0] lo, input reg_addr_t d,
                          input uint32_t res, input logic mfc0, input uint32_t pc);
    es_to_ms_valid = 1'b1;
    es_load_op     = op;
    es_addr_lo     = lo;
    es_dest        = d;
    es_result      = res;
    es_mfc0        = mfc0;
    es_pc          = pc;
  endtask

  // One transaction from EMPTY back to EMPTY; writeback stalls until the result is checked.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    ws_allowin = 1'b0;
    drive_op(v.op, v.addr_lo, v.dest, (v.op == NONE) ? v.data : 32'h0BAD_0000, 1'b0, 32'h1000 + 32'(idx));
    #1 check({tag, "_allowin"}, 32'(ms_allowin), 1);
    next_cycle();
    es_to_ms_valid = 1'b0;
    if (v.op != NONE) begin
      #1;
      check({tag, "_pending"}, 32'(ms_data_pending), 1);
      check({tag, "_wait_we"}, 32'(ms_rf_we), 0);
      check({tag, "_wait_dest"}, 32'(ms_dest), 32'(v.dest));
      data_ok    = 1'b1;
      data_rdata = v.data;
      next_cycle();
      data_ok    = 1'b0;
      data_rdata = '0;
    end
    #1;
    check({tag, "_valid"}, 32'(ms_to_ws_valid), 1);
    check({tag, "_result"}, ms_result, v.exp_result);
    check({tag, "_we"}, 32'(ms_rf_we), 32'(v.exp_we));
    check({tag, "_pc"}, ms_pc, 32'h1000 + 32'(idx));
    ws_allowin = 1'b1;
    next_cycle();
    ws_allowin = 1'b0;
    #1 check({tag, "_empty"}, 32'(ms_to_ws_valid), 0);
  endtask

  initial begin
    vecs[0]  = '{LW,   2'd0, 5'd5, 32'h11223344, 32'h11223344, 4'b1111};
    vecs[1]  = '{LB,   2'd3, 5'd5, 32'h80FF0000, 32'hFFFFFF80, 4'b1111};
    vecs[2]  = '{LBU,  2'd3, 5'd5, 32'h80FF0000, 32'h00000080, 4'b1111};
    vecs[3]  = '{LWL,  2'd1, 5'd5, 32'hAABBCCDD, 32'hCCDD0000, 4'b1100};
    vecs[4]  = '{LWR,  2'd2, 5'd5, 32'hAABBCCDD, 32'h0000AABB, 4'b0011};
    vecs[5]  = '{LB,   2'd1, 5'd7, 32'h12345678, 32'h00000056, 4'b1111};
    vecs[6]  = '{LH,   2'd2, 5'd7, 32'h80011234, 32'hFFFF8001, 4'b1111};
    vecs[7]  = '{LHU,  2'd2, 5'd7, 32'h80011234, 32'h00008001, 4'b1111};
    vecs[8]  = '{LH,   2'd0, 5'd7, 32'h80017FFF, 32'h00007FFF, 4'b1111};
    vecs[9]  = '{LWL,  2'd0, 5'd8, 32'hAABBCCDD, 32'hDD000000, 4'b1000};
    vecs[10] = '{LWL,  2'd3, 5'd8, 32'hAABBCCDD, 32'hAABBCCDD, 4'b1111};
    vecs[11] = '{LWR,  2'd0, 5'd8, 32'hAABBCCDD, 32'hAABBCCDD, 4'b1111};
    vecs[12] = '{LWR,  2'd3, 5'd8, 32'hAABBCCDD, 32'h000000AA, 4'b0001};
    vecs[13] = '{LWL,  2'd2, 5'd8, 32'hAABBCCDD, 32'hBBCCDD00, 4'b1110};
    vecs[14] = '{LWR,  2'd1, 5'd8, 32'hAABBCCDD, 32'h00AABBCC, 4'b0111};
    vecs[15] = '{LW,   2'd0, 5'd0, 32'h11223344, 32'h11223344, 4'b0000};
    vecs[16] = '{NONE, 2'd0, 5'd9, 32'hDEADBEEF, 32'hDEADBEEF, 4'b1111};
    vecs[17] = '{NONE, 2'd0, 5'd0, 32'hCAFEF00D, 32'hCAFEF00D, 4'b0000};

    reset = 1'b1;
    es_to_ms_valid = 1'b0; es_load_op = NONE; es_addr_lo = '0; es_dest = '0;
    es_result = '0; es_mfc0 = 1'b0; es_pc = '0;
    data_ok = 1'b0; data_rdata = '0; ws_allowin = 1'b0; flush = 1'b0;
    next_cycle();
    next_cycle();
    check("rst_valid",   32'(ms_to_ws_valid), 0);
    check("rst_allowin", 32'(ms_allowin), 1);
    check("rst_we",      32'(ms_rf_we), 0);
    check("rst_dest",    32'(ms_dest), 0);
    check("rst_mfc0",    32'(ms_mfc0), 0);
    check("rst_pending", 32'(ms_data_pending), 0);
    check("rst_result",  ms_result, 0);
    check("rst_pc",      ms_pc, 0);
    reset = 1'b0;
    next_cycle();

    for (int i = 0; i < 18; i++) run_vec(i, vecs[i]);

    // LW with the response two cycles after acceptance; valid only after data_ok.
    drive_op(LW, 2'd0, 5'd6, 32'h0, 1'b0, 32'h2000);
    next_cycle();
    es_to_ms_valid = 1'b0;
    #1 check("lw2_wait1_valid", 32'(ms_to_ws_valid), 0);
    next_cycle();
    data_ok = 1'b1; data_rdata = 32'h11223344;
    #1 check("lw2_dok_valid", 32'(ms_to_ws_valid), 0);
    check("lw2_dok_allowin", 32'(ms_allowin), 0);
    next_cycle();
    data_ok = 1'b0; data_rdata = '0;
    #1 check("lw2_valid", 32'(ms_to_ws_valid), 1);
    check("lw2_result", ms_result, 32'h11223344);
    check("lw2_we", 32'(ms_rf_we), 32'hF);
    ws_allowin = 1'b1;
    next_cycle();
    ws_allowin = 1'b0;

    // Flush while waiting: response three cycles later is dropped.
    drive_op(LW, 2'd0, 5'd3, 32'h0, 1'b0, 32'h3000);
    next_cycle();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    #1 check("fl_wait_valid", 32'(ms_to_ws_valid), 0);
    next_cycle();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_op(NONE, 2'd0, 5'd12, 32'h5555, 1'b0, 32'h3100);
      #1;
      check($sformatf("fl_disc%0d_allowin", i), 32'(ms_allowin), 0);
      check($sformatf("fl_disc%0d_valid", i), 32'(ms_to_ws_valid), 0);
      check($sformatf("fl_disc%0d_dest", i), 32'(ms_dest), 0);
      next_cycle();
    end
    es_to_ms_valid = 1'b0;
    data_ok = 1'b1; data_rdata = 32'h99999999;
    #1 check("fl_dok_allowin", 32'(ms_allowin), 0);
    check("fl_dok_valid", 32'(ms_to_ws_valid), 0);
    next_cycle();
    data_ok = 1'b0; data_rdata = '0;
    #1 check("fl_after_allowin", 32'(ms_allowin), 1);
    check("fl_after_valid", 32'(ms_to_ws_valid), 0);
    check("fl_after_pending", 32'(ms_data_pending), 0);

    // Flush overrides acceptance in EMPTY, and squashes a READY op.
    drive_op(NONE, 2'd0, 5'd4, 32'h4444, 1'b0, 32'h4000);
    flush = 1'b1;
    next_cycle();
    flush = 1'b0;
    es_to_ms_valid = 1'b0;
    #1 check("fl_empty_valid", 32'(ms_to_ws_valid), 0);
    check("fl_empty_dest", 32'(ms_dest), 0);
    drive_op(NONE, 2'd0, 5'd4, 32'h4444, 1'b0, 32'h4004);
    next_cycle();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    #1 check("fl_ready_valid", 32'(ms_to_ws_valid), 0);
    next_cycle();
    flush = 1'b0;
    #1 check("fl_ready_empty", 32'(ms_allowin), 1);
    check("fl_ready_we", 32'(ms_rf_we), 0);

    // Back-to-back ALU ops, then writeback back-pressure.
    ws_allowin = 1'b1;
    drive_op(NONE, 2'd0, 5'd10, 32'h100, 1'b1, 32'hBFC00000);
    next_cycle();
    drive_op(NONE, 2'd0, 5'd0, 32'h200, 1'b0, 32'hBFC00004);
    #1 check("b2b_a_valid", 32'(ms_to_ws_valid), 1);
    check("b2b_a_result", ms_result, 32'h100);
    check("b2b_a_we", 32'(ms_rf_we), 32'hF);
    check("b2b_a_mfc0", 32'(ms_mfc0), 1);
    check("b2b_a_pc", ms_pc, 32'hBFC00000);
    check("b2b_a_allowin", 32'(ms_allowin), 1);
    next_cycle();
    drive_op(NONE, 2'd0, 5'd11, 32'h300, 1'b0, 32'hBFC00008);
    ws_allowin = 1'b0;
    #1 check("b2b_b_result", ms_result, 32'h200);
    check("b2b_b_we", 32'(ms_rf_we), 0);
    check("b2b_b_allowin", 32'(ms_allowin), 0);
    for (int i = 0; i < 2; i++) begin
      next_cycle();
      #1;
      check($sformatf("hold%0d_valid", i), 32'(ms_to_ws_valid), 1);
      check($sformatf("hold%0d_result", i), ms_result, 32'h200);
      check($sformatf("hold%0d_pc", i), ms_pc, 32'hBFC00004);
    end
    ws_allowin = 1'b1;
    next_cycle();
    es_to_ms_valid = 1'b0;
    #1 check("b2b_c_result", ms_result, 32'h300);
    check("b2b_c_dest", 32'(ms_dest), 11);
    check("b2b_c_we", 32'(ms_rf_we), 32'hF);
    next_cycle();
    ws_allowin = 1'b0;
    #1 check("b2b_end_valid", 32'(ms_to_ws_valid), 0);

    // Reset while waiting abandons the load; a stray response in EMPTY is ignored.
    drive_op(LW, 2'd0, 5'd13, 32'h0, 1'b0, 32'h5000);
    next_cycle();
    es_to_ms_valid = 1'b0;
    #2 reset = 1'b1;
    #1 check("rstw_pending", 32'(ms_data_pending), 0);
    check("rstw_allowin", 32'(ms_allowin), 1);
    check("rstw_dest", 32'(ms_dest), 0);
    next_cycle();
    reset = 1'b0;
    data_ok = 1'b1; data_rdata = 32'h77777777;
    next_cycle();
    data_ok = 1'b0;
    #1 check("stray_valid", 32'(ms_to_ws_valid), 0);
    check("stray_we", 32'(ms_rf_we), 0);
    check("stray_result", ms_result, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
